// File: rtl/mmc_cmd_ctrl.sv
// MMC CMD-line sequencer: frames a command with CRC7, shifts it out, then
// optionally turns the line around and captures a 48-bit response.
module mmc_cmd_ctrl #(
  parameter int CLKDIV  = 4,
  parameter int TIMEOUT = 64,
  parameter int NCC     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_resp_en,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [5:0]  rsp_index,
  output logic [31:0] rsp_arg,
  output logic        busy,
  output logic        cmd_o,
  output logic        cmd_oe,
  input  logic        cmd_i
);

  localparam int DW = $clog2(CLKDIV);
  localparam int CW = 16;

  typedef enum logic [2:0] {IDLE, TX, TURN, WAIT, RX, GAP, DONE} state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  div_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [47:0]    frame_q;
  logic           resp_en_q;
  logic [45:0]    rx_q;
  logic [1:0]     res_status_q, rsp_status_q;
  logic [5:0]     res_index_q, rsp_index_q;
  logic [31:0]    res_arg_q, rsp_arg_q;
  logic           tick;
  logic [47:0]    rx_word;
  logic [6:0]     rx_crc, tx_crc;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign tick    = (div_q == DW'(CLKDIV - 1));
  // Start bit is implied; the final tick's bit completes the response word.
  assign rx_word = {1'b0, rx_q, cmd_i};
  assign rx_crc  = crc7(rx_word[47:8]);
  assign tx_crc  = crc7({2'b01, cmd_index, cmd_arg});

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = TX;
        cnt_d   = '0;
      end
      TX: if (tick) begin
        if (cnt_q == CW'(47)) begin
          state_d = resp_en_q ? TURN : GAP;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      TURN: if (tick) begin
        if (cnt_q == CW'(1)) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      WAIT: if (tick) begin
        if (!cmd_i) begin
          state_d = RX;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      RX: if (tick) begin
        if (cnt_q == CW'(46)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      GAP: if (tick) begin
        if (cnt_q == CW'(NCC - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    cmd_oe    = 1'b0;
    cmd_o     = 1'b1;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      TX: begin
        cmd_oe = 1'b1;
        cmd_o  = frame_q[47];
      end
      GAP:     cmd_oe = 1'b1;
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      cnt_q        <= '0;
      frame_q      <= '1;
      resp_en_q    <= 1'b0;
      rx_q         <= '0;
      res_status_q <= 2'b00;
      res_index_q  <= '0;
      res_arg_q    <= '0;
      rsp_status_q <= 2'b00;
      rsp_index_q  <= '0;
      rsp_arg_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == IDLE || state_d != state_q || tick) div_q <= '0;
      else                                               div_q <= div_q + 1'b1;

      if (state_q == IDLE && cmd_valid) begin
        frame_q      <= {2'b01, cmd_index, cmd_arg, tx_crc, 1'b1};
        resp_en_q    <= cmd_resp_en;
        res_status_q <= 2'b00;
      end
      if (state_q == TX && tick) frame_q <= {frame_q[46:0], 1'b1};
      if (state_q == WAIT && tick) begin
        rx_q <= '0;
        if (cmd_i && cnt_q == CW'(TIMEOUT - 1)) begin
          res_status_q <= 2'b01;
          res_index_q  <= '0;
          res_arg_q    <= '0;
        end
      end
      if (state_q == RX && tick) begin
        rx_q <= {rx_q[44:0], cmd_i};
        if (cnt_q == CW'(46)) begin
          res_index_q <= rx_word[45:40];
          res_arg_q   <= rx_word[39:8];
          if (rx_crc != rx_word[7:1]) res_status_q <= 2'b10;
          else if (!rx_word[0])       res_status_q <= 2'b11;
          else                        res_status_q <= 2'b00;
        end
      end
      if (state_q == GAP && state_d == DONE) begin
        rsp_status_q <= res_status_q;
        rsp_index_q  <= res_index_q;
        rsp_arg_q    <= res_arg_q;
      end
    end
  end

  assign rsp_status = rsp_status_q;
  assign rsp_index  = rsp_index_q;
  assign rsp_arg    = rsp_arg_q;

endmodule

// File: tb/tb_mmc_cmd_ctrl.sv
// Directed bench for mmc_cmd_ctrl: expected results are queued at command
// issue and checked by a monitor when rsp_valid fires.
module tb_mmc_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic        cmd_resp_en = 1'b0;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [5:0]  rsp_index;
  logic [31:0] rsp_arg;
  logic        busy;
  logic        cmd_o;
  logic        cmd_oe;
  logic        cmd_i = 1'b1;

  mmc_cmd_ctrl #(.CLKDIV(4), .TIMEOUT(64), .NCC(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_resp_en(cmd_resp_en),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .rsp_index(rsp_index), .rsp_arg(rsp_arg),
    .busy(busy), .cmd_o(cmd_o), .cmd_oe(cmd_oe), .cmd_i(cmd_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        chk_data;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   hs_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rsp_count = 0;
  logic prev_oe = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) hs_q.push_back(cyc);
  end

  always @(negedge clk) begin
    exp_t e;
    int   h;
    if (rsp_valid) begin
      rsp_count++;
      chk("rsp_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0 && hs_q.size() != 0) begin
        e = exp_q.pop_front();
        h = hs_q.pop_front();
        chk("rsp_status", 64'(rsp_status), 64'(e.st));
        if (e.chk_data) begin
          chk("rsp_index", 64'(rsp_index), 64'(e.idx));
          chk("rsp_arg", 64'(rsp_arg), 64'(e.arg));
        end
        chk("rsp_latency", 64'(cyc - h), 64'(e.lat));
        chk("done_oe_low", 64'(cmd_oe), 64'(0));
        chk("done_busy", 64'(busy), 64'(1));
        chk("gap_oe_high", 64'(prev_oe), 64'(1));
        $display("rsp cyc=%0d lat=%0d status=%0b index=%0h arg=%08h", cyc, cyc - h,
                 rsp_status, rsp_index, rsp_arg);
      end
    end
    prev_oe = cmd_oe;
  end

  task automatic handshake(input logic [5:0] idx, input logic [31:0] arg, input logic ren);
    int n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 64'(cmd_ready), 64'(1));
    cmd_index   = idx;
    cmd_arg     = arg;
    cmd_resp_en = ren;
    cmd_valid   = 1'b1;
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
    cmd_index   = 6'($urandom);
    cmd_arg     = $urandom;
    cmd_resp_en = 1'($urandom);
  endtask

  // mode: 0 no response driven, 1 good, 2 bad CRC, 3 bad CRC + end 0, 4 end 0
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic ren,
                         input logic [47:0] frame, input int mode, input exp_t e);
    logic [39:0] w40;
    logic [6:0]  c;
    logic        endb;
    logic [47:0] rsp;
    int          bad;
    exp_q.push_back(e);
    handshake(idx, arg, ren);
    bad = 0;
    for (int k = 0; k < 192; k++) begin
      @(negedge clk);
      if (cmd_o !== frame[47 - k / 4] || cmd_oe !== 1'b1) bad++;
    end
    chk("tx_frame_bits", 64'(bad), 64'(0));
    if (mode != 0) begin
      w40  = {2'b00, e.idx, e.arg};
      c    = crc7(w40);
      if (mode == 2 || mode == 3) c = c ^ 7'h01;
      endb = !(mode == 3 || mode == 4);
      rsp  = {w40, c, endb};
      for (int k = 0; k < 28; k++) begin
        @(negedge clk);
        cmd_i = 1'b1;
      end
      for (int b = 47; b >= 0; b--) begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          cmd_i = rsp[b];
        end
      end
      @(negedge clk);
      cmd_i = 1'b1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int   d1;
    int   bad;
    int   cnt0;
    exp_t e;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_status", 64'(rsp_status), 64'(0));
    chk("rst_index", 64'(rsp_index), 64'(0));
    chk("rst_arg", 64'(rsp_arg), 64'(0));
    chk("rst_cmd_o", 64'(cmd_o), 64'(1));
    chk("rst_cmd_oe", 64'(cmd_oe), 64'(0));
    rst = 1'b0;

    e = '{st: 2'b00, idx: 6'h00, arg: 32'h0, chk_data: 1'b0, lat: 225};
    run_cmd(6'd0, 32'h0, 1'b0, 48'h40_0000_0000_95, 0, e);
    wait_drain();

    e = '{st: 2'b00, idx: 6'h08, arg: 32'h1AA, chk_data: 1'b1, lat: 445};
    run_cmd(6'd8, 32'h1AA, 1'b1, 48'h48_0000_01AA_87, 1, e);
    wait_drain();
    e.st = 2'b10;
    run_cmd(6'd8, 32'h1AA, 1'b1, 48'h48_0000_01AA_87, 2, e);
    wait_drain();
    run_cmd(6'd8, 32'h1AA, 1'b1, 48'h48_0000_01AA_87, 3, e);
    wait_drain();
    e.st = 2'b11;
    run_cmd(6'd8, 32'h1AA, 1'b1, 48'h48_0000_01AA_87, 4, e);
    wait_drain();

    e = '{st: 2'b01, idx: 6'h00, arg: 32'h0, chk_data: 1'b1, lat: 489};
    run_cmd(6'd8, 32'h1AA, 1'b1, 48'h48_0000_01AA_87, 0, e);
    wait_drain();

    // cmd_valid held high across two commands
    e = '{st: 2'b00, idx: 6'h00, arg: 32'h0, chk_data: 1'b0, lat: 225};
    exp_q.push_back(e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    cmd_index = 6'd0; cmd_arg = 32'h0; cmd_resp_en = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_index = 6'd2; cmd_arg = 32'h1234; cmd_resp_en = 1'b0;
    bad = 0;
    d1  = -1;
    for (int k = 0; k < 400 && d1 < 0; k++) begin
      @(negedge clk);
      if (rsp_valid) d1 = cyc;
      else if (cmd_ready !== 1'b0) bad++;
    end
    chk("b2b_ready_low", 64'(bad), 64'(0));
    @(negedge clk);
    chk("b2b_ready_after_done", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("b2b_hs_cycle", 64'(hs_q.size() != 0 ? hs_q[0] : -1), 64'(d1 + 1));
    wait_drain();

    // reset mid-TX
    handshake(6'd17, 32'hDEADBEEF, 1'b1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_cmd_oe", 64'(cmd_oe), 64'(0));
    chk("midrst_cmd_o", 64'(cmd_o), 64'(1));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_ready", 64'(cmd_ready), 64'(1));
    rst = 1'b0;
    hs_q.delete();
    cnt0 = rsp_count;
    repeat (600) @(negedge clk);
    chk("midrst_no_rsp", 64'(rsp_count - cnt0), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmc_cmd_ctrl.md
Name: mmc_cmd_ctrl

Overview:
Command-line sequencer for the MMC subsystem. It accepts a command request (index, argument, response-expected flag) over a valid/ready handshake and frames it as a 48-bit MMC command with a generated CRC7. It shifts the frame out on the open-drain-style CMD line, turns the line around, and waits for and captures a 48-bit response with CRC/end-bit checking. It reports the result on a one-cycle response strobe and sits between the MMC register/host logic and the CMD pad cell.

Parameters:
CLKDIV, 4, clk cycles per CMD bit period; legal values are 2 or more.
TIMEOUT, 64, bit periods to wait for a response start bit before flagging timeout.
NCC, 8, idle bit periods driven high after each transaction before rsp_valid.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command request valid
cmd_ready  output  1  block can accept a command; high only in IDLE
cmd_index  input  6  command index
cmd_arg  input  32  command argument
cmd_resp_en  input  1  1 = expect 48-bit response
rsp_valid  output  1  one-cycle completion strobe
rsp_status  output  2  00 ok, 01 timeout, 10 CRC error, 11 end-bit error
rsp_index  output  6  response bits [45:40]
rsp_arg  output  32  response bits [39:8]
busy  output  1  high whenever state is not IDLE
cmd_o  output  1  CMD line drive value
cmd_oe  output  1  CMD line output enable
cmd_i  input  1  CMD line sampled value

Behaviour:
- Interface decision: one clock, clk; synchronous active-high reset, rst. All state updates on rising clk.
- Reset values: state=IDLE, cmd_ready=1, busy=0, rsp_valid=0, rsp_status=00, rsp_index=0, rsp_arg=0, cmd_o=1, cmd_oe=0, divider=0.
- Reset mid-operation: rst returns the block to IDLE at the next edge with the values above. No rsp_valid is issued for the aborted command.
- Bit timing:
  - The divider counts 0..CLKDIV-1 in every non-IDLE state. A tick occurs at count CLKDIV-1.
  - The divider clears on every state transition, so each bit holds for exactly CLKDIV cycles.
  - cmd_i is sampled only on tick cycles, i.e. the last cycle of each bit period.
- Frame layout:
  - [47]=0 (start), [46]=1 (transmission), [45:40]=cmd_index, [39:8]=cmd_arg, [7:1]=CRC7, [0]=1 (end).
  - CRC7 polynomial is x^7+x^3+1, initial value 0, computed over bits [47:8] MSB-first.
- States:
  - IDLE: cmd_ready=1, cmd_oe=0, cmd_o=1. On cmd_valid & cmd_ready, latch the frame and go to TX.
  - TX: cmd_oe=1. cmd_o = frame[47] in the first cycle after the handshake, MSB-first, one bit per CLKDIV cycles, 48 bits in total. After the 48th tick, go to TURN if cmd_resp_en was latched high, else to GAP.
  - TURN: cmd_oe=0 for 2 bit periods, then go to WAIT.
  - WAIT: cmd_oe=0.
    - cmd_i==0 on a tick: that bit is the start bit; go to RX.
    - TIMEOUT ticks without a start bit: status=01, rsp_index=0, rsp_arg=0, go to GAP.
    - A start bit on the final permitted tick counts as a start bit, not a timeout.
  - RX: shift in the remaining 47 bits on ticks. Then compute the status:
    - CRC mismatch over received [47:8] vs [7:1]: 10.
    - Otherwise end bit [0]==0: 11.
    - Otherwise: 00.
    - CRC error takes precedence over end-bit error.
    - rsp_index and rsp_arg are updated even on error. Then go to GAP.
  - GAP: cmd_oe=1, cmd_o=1 for NCC bit periods, then go to DONE.
  - DONE: rsp_valid=1 for exactly one cycle, busy=1, cmd_oe=0; next state is IDLE.
- rsp_status, rsp_index and rsp_arg hold their values until the next DONE or reset.
- Latency without response: rsp_valid is high exactly (48+NCC)*CLKDIV+1 cycles after the handshake cycle; 225 cycles at defaults.
- cmd_valid is ignored while not IDLE. Request fields are not required to remain stable after the handshake.

Test Plan:
- Reset: hold rst for 3 cycles mid-TX -> next cycle cmd_oe=0, cmd_o=1, busy=0, cmd_ready=1; no rsp_valid afterwards.
- CMD0, arg 0x00000000, cmd_resp_en=0, CLKDIV=4 -> cmd_o serialises 48'h40_0000_0000_95, each bit held 4 cycles. rsp_valid at cycle 225 after the handshake with status 00. cmd_oe falls in the DONE cycle.
- CMD8, arg 0x000001AA, cmd_resp_en=1 -> TX frame 48'h48_0000_01AA_87. Bench drives response 0x08, 0x000001AA with a model-computed CRC7 and end bit 1, starting 5 bit periods after TURN -> status 00, rsp_index=0x08, rsp_arg=0x000001AA.
- Same CMD8, but the bench flips one CRC bit, and in a second run also clears the end bit -> status 10 in both runs. In a third run with a good CRC and end bit 0 -> status 11.
- cmd_i held at 1 -> status 01 exactly TIMEOUT (64) bit periods into WAIT, then 8 gap periods, then rsp_valid, with rsp_arg=0.
- cmd_valid held high continuously across two commands -> the second handshake occurs in the IDLE cycle right after the DONE cycle. cmd_ready stays 0 throughout the first command.
